add3_share_arb: RTL
===================

Name: add3_share_arb

Overview:
Round-robin arbiter/sequencer that shares one 3-operand adder (add3_operator datapath, Y = A+B+C mod 2^WIDTH) between NREQ requesters. Each requester presents A/B/C with a request. The block grants one requester per accept cycle, registers the sum, and returns it with the requester ID over a valid/ready response port. It sits between the client blocks and the single shared adder instance.

Parameters:
WIDTH, 8, operand/sum width in bits
NREQ, 4, number of requesters (2..16)
IDW, $clog2(NREQ), width of requester ID (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  per-requester request; held high with operands stable until granted
op_a  in  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
op_b  in  NREQ*WIDTH  operand B, same packing
op_c  in  NREQ*WIDTH  operand C, same packing
gnt  out  NREQ  one-hot accept strobe; operands of gnt[i] sampled at this clock edge
rsp_valid  out  1  registered result available
rsp_id  out  IDW  requester index of held result
rsp_sum  out  WIDTH  registered (A+B+C) mod 2^WIDTH
rsp_ready  in  1  consumer accepts result when rsp_valid && rsp_ready
op_count  out  16  number of completed (handshaken) responses; wraps at 16'hFFFF -> 0

Behaviour:
- Reset (async assert, sync release): state=IDLE, rsp_valid=0, rsp_id=0, rsp_sum=0, op_count=0, rr pointer=0 (requester 0 highest priority). gnt=0 while rst_n low.
- FSM, 2 states:
  - IDLE: rsp_valid=0. If |req, then gnt=onehot(winner) combinationally. Next edge: rsp_sum<=sum(winner), rsp_id<=winner, rsp_valid<=1, go to HOLD. If !|req, stay in IDLE, gnt=0.
  - HOLD: rsp_valid=1; outputs stable until handshake.
    - !rsp_ready: gnt=0, stay in HOLD; req is ignored.
    - rsp_ready && |req: back-to-back. gnt to the new winner in the same cycle; the register loads the new result; stay in HOLD; op_count++.
    - rsp_ready && !|req: go to IDLE, rsp_valid<=0, op_count++.
- Throughput: 1 op/cycle under continuous rsp_ready. Latency: gnt cycle -> rsp_valid next cycle (1 clock).
- gnt is a function of state, req, rsp_ready and the pointer only. At most one bit is set. gnt[i] implies req[i].
- Round-robin: winner = first i with req[i]=1, searching from pointer upward mod NREQ. On grant to i, pointer <= (i+1) mod NREQ. Pointer is unchanged when there is no grant.
- Arithmetic: sum = (A+B+C) truncated to WIDTH bits. All carries are discarded (e.g. WIDTH=8: FF+FF+FF=FD).
- A request dropped before grant is legal and is simply not served. The requester may change operands only after its gnt.
- Reset mid-operation: any held result is lost, rsp_valid drops immediately (async), and the pointer returns to 0.
- No X on outputs after reset regardless of req values.

Decomposition:
- Shared package add3_pkg:
  - state enum {IDLE, HOLD}
  - localparam for op_count width (16)
  - function for the next rr pointer
- Sub-module rr_arbiter #(NREQ): inputs req and pointer; outputs one-hot gnt and encoded winner index. Purely combinational.
- Top: FSM, pointer register, output registers and counter. It instantiates one add3_operator #(WIDTH) on the muxed operands of the winner.

Test Plan:
1. Reset: hold rst_n=0 with req=4'hF -> gnt=0, rsp_valid=0, rsp_sum=0, op_count=0. Release, keep req=0 -> remains IDLE.
2. Single op: WIDTH=8, req=4'b0100, A=12, B=34, C=56, rsp_ready=1 -> gnt=4'b0100 in that cycle. Next cycle rsp_valid=1, rsp_id=2, rsp_sum=8'h66, then op_count=1.
3. Overflow: A=B=C=8'hFF for requester 0 -> rsp_sum=8'hFD. A=8'h80, B=8'h80, C=0 -> 8'h00.
4. Round-robin fairness: req=4'hF held, rsp_ready=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3, one per cycle. rsp_valid stays high throughout; op_count=8 after draining.
5. Backpressure: rsp_ready=0 for 5 cycles with req=4'b0011 pending -> gnt=0 and rsp_sum/rsp_id held stable. Raise rsp_ready -> next grant goes to the pointer's requester in the same cycle, with no result lost or duplicated.
6. Reset mid-HOLD: rsp_valid=1, pull rst_n low mid-cycle -> rsp_valid=0 asynchronously. After release with req=4'b1000, the pointer is 0 and gnt=4'b1000; with req=4'b1001, gnt=4'b0001.

Source files
------------

// File: rtl/add3_pkg.sv
// Shared types and helpers for the add3_share_arb round-robin adder sharing block.
package add3_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int CNT_W = 16;

    // Pointer moves to the requester just after the one granted, wrapping at nreq.
    function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned nreq);
        return (idx + 1 >= nreq) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/add3_share_arb_if.sv
// Request/response bundle between the clients and the shared 3-operand adder arbiter.
interface add3_share_arb_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
);
    import add3_pkg::*;

    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] op_a;
    logic [NREQ*WIDTH-1:0] op_b;
    logic [NREQ*WIDTH-1:0] op_c;
    logic [NREQ-1:0]       gnt;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_ready;
    logic [CNT_W-1:0]      op_count;

    modport master (
        output req, op_a, op_b, op_c, rsp_ready,
        input  gnt, rsp_valid, rsp_id, rsp_sum, op_count
    );

    modport slave (
        input  req, op_a, op_b, op_c, rsp_ready,
        output gnt, rsp_valid, rsp_id, rsp_sum, op_count
    );

endinterface

// File: rtl/add3_operator.sv
// Shared adder datapath: y = a + b + c, carries out of WIDTH bits are discarded.
module add3_operator #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] y
);

    assign y = a + b + c;

endmodule

// File: rtl/add3_share_arb_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping mod NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  winner
);

    logic           found;
    logic [IDW:0]   raw;
    logic [IDW-1:0] idx;

    always_comb begin
        gnt    = '0;
        winner = '0;
        found  = 1'b0;
        raw    = '0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            // One extra bit keeps ptr+k from overflowing before the modulo wrap.
            raw = {1'b0, ptr} + (IDW+1)'(k);
            if (raw >= (IDW+1)'(NREQ)) begin
                raw = raw - (IDW+1)'(NREQ);
            end
            idx = raw[IDW-1:0];
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                winner   = idx;
            end
        end
    end

endmodule

// File: rtl/add3_share_arb.sv
// Round-robin sequencer sharing one add3_operator among NREQ requesters, with a
// registered valid/ready result port and a handshake counter.
module add3_share_arb #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input logic            clk,
    input logic            rst_n,
    add3_share_arb_if.slave bus
);
    import add3_pkg::*;

    localparam int IDW = $clog2(NREQ);

    state_t           state, state_n;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   winner;
    logic [NREQ-1:0]  arb_gnt;
    logic             accept;
    logic             done;
    logic [WIDTH-1:0] a_sel, b_sel, c_sel, sum;
    logic             rsp_valid;
    logic [IDW-1:0]   rsp_id;
    logic [WIDTH-1:0] rsp_sum;
    logic [CNT_W-1:0] op_count;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req    (bus.req),
        .ptr    (ptr),
        .gnt    (arb_gnt),
        .winner (winner)
    );

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        c_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == IDW'(i)) begin
                a_sel = bus.op_a[i*WIDTH +: WIDTH];
                b_sel = bus.op_b[i*WIDTH +: WIDTH];
                c_sel = bus.op_c[i*WIDTH +: WIDTH];
            end
        end
    end

    add3_operator #(.WIDTH(WIDTH)) u_add (
        .a (a_sel),
        .b (b_sel),
        .c (c_sel),
        .y (sum)
    );

    // A new grant is only possible when the output register is free or being drained now.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    accept  = 1'b1;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (bus.rsp_ready) begin
                    done = 1'b1;
                    if (|bus.req) begin
                        accept = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        accept = accept & rst_n;
    end

    assign bus.gnt = accept ? arb_gnt : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            op_count  <= '0;
        end else begin
            if (accept) begin
                rsp_valid <= 1'b1;
                rsp_id    <= winner;
                rsp_sum   <= sum;
                ptr       <= IDW'(next_ptr(32'(winner), NREQ));
            end else if (done) begin
                rsp_valid <= 1'b0;
            end
            if (done) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_id    = rsp_id;
    assign bus.rsp_sum   = rsp_sum;
    assign bus.op_count  = op_count;

endmodule
